// File: rtl/mole_game_ctrl_pkg.sv
// Shared state encoding, display constants and LFSR / position helpers for the mole game.
package mole_game_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SPAWN = 3'd1,
      S_UP    = 3'd2,
      S_GAP   = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [3:0]  NO_MOLE   = 4'b1111;
   localparam int          BCD_W     = 4;
   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Never repeat the previous hole: bump a collision to the next position.
   function automatic logic [1:0] pick_pos(input logic [1:0] raw, input logic [1:0] prev);
      return (raw == prev) ? raw + 2'd1 : raw;
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter: synchronous clear, increment with ripple carry, holds at 9999.
module bcd_counter4
   import mole_game_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] thou,
   output logic [BCD_W-1:0] hund,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   logic [3:0][BCD_W-1:0] dig_q, dig_d;
   logic                  carry;
   logic                  at_max;

   always_comb begin
      dig_d  = dig_q;
      carry  = 1'b1;
      at_max = (dig_q == 16'h9999);
      if (clr) begin
         dig_d = '0;
      end else if (inc && !at_max) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (dig_q[i] == BCD_W'(9)) begin
                  dig_d[i] = '0;
               end else begin
                  dig_d[i] = dig_q[i] + BCD_W'(1);
                  carry    = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dig_q <= '0;
      end else begin
         dig_q <= dig_d;
      end
   end

   assign thou = dig_q[3];
   assign hund = dig_q[2];
   assign tens = dig_q[1];
   assign ones = dig_q[0];

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-Mole controller: LFSR mole placement, up/gap timing, hit judging and BCD score.
// All outputs are registered; the mole appears one cycle after SPAWN and clears on the edge that samples the button.
module mole_game_ctrl
   import mole_game_ctrl_pkg::*;
#(
   parameter logic [31:0] UP_CYCLES  = 32'd50_000_000,
   parameter logic [31:0] UP_STEP    = 32'd2_500_000,
   parameter logic [31:0] UP_MIN     = 32'd10_000_000,
   parameter logic [31:0] GAP_CYCLES = 32'd25_000_000,
   parameter logic [31:0] ROUNDS     = 32'd20,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       btn,
   output logic [3:0]       mole_location,
   output logic             level_mode,
   output logic [BCD_W-1:0] an_thou,
   output logic [BCD_W-1:0] an_hund,
   output logic [BCD_W-1:0] an_tens,
   output logic [BCD_W-1:0] an_ones
);

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [31:0] round_q, round_d;
   logic [31:0] up_len_q, up_len_d;
   logic [31:0] timer_q, timer_d;
   logic [1:0]  prev_pos_q, prev_pos_d;
   logic [3:0]  mole_q, mole_d;
   logic        level_q, level_d;

   logic        score_clr;
   logic        score_inc;
   logic [1:0]  spawn_pos;
   logic        hit;
   logic        wrong;

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_step(lfsr_q);
      round_d    = round_q;
      up_len_d   = up_len_q;
      timer_d    = timer_q;
      prev_pos_d = prev_pos_q;
      mole_d     = mole_q;
      level_d    = level_q;
      score_clr  = 1'b0;
      score_inc  = 1'b0;
      spawn_pos  = pick_pos(lfsr_q[1:0], prev_pos_q);
      // While UP, prev_pos_q holds the hole of the mole currently showing.
      hit        = btn[prev_pos_q];
      wrong      = |(btn & ~(4'b0001 << prev_pos_q));

      case (state_q)
         S_IDLE, S_OVER: begin
            level_d = 1'b1;
            mole_d  = NO_MOLE;
            if (start) begin
               state_d   = S_SPAWN;
               score_clr = 1'b1;
               round_d   = '0;
               up_len_d  = UP_CYCLES;
            end
         end
         S_SPAWN: begin
            mole_d     = ~(4'b0001 << spawn_pos);
            prev_pos_d = spawn_pos;
            level_d    = 1'b0;
            timer_d    = up_len_q - 32'd1;
            state_d    = S_UP;
         end
         S_UP: begin
            if (hit || wrong || (timer_q == '0)) begin
               mole_d  = NO_MOLE;
               timer_d = GAP_CYCLES - 32'd1;
               round_d = round_q + 32'd1;
               state_d = S_GAP;
               if (hit) begin
                  score_inc = 1'b1;
                  up_len_d  = (up_len_q >= UP_MIN + UP_STEP) ? (up_len_q - UP_STEP) : UP_MIN;
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               state_d = (round_q == ROUNDS) ? S_OVER : S_SPAWN;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         round_q    <= '0;
         up_len_q   <= UP_CYCLES;
         timer_q    <= '0;
         prev_pos_q <= '0;
         mole_q     <= NO_MOLE;
         level_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         round_q    <= round_d;
         up_len_q   <= up_len_d;
         timer_q    <= timer_d;
         prev_pos_q <= prev_pos_d;
         mole_q     <= mole_d;
         level_q    <= level_d;
      end
   end

   bcd_counter4 u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr),
      .inc   (score_inc),
      .thou  (an_thou),
      .hund  (an_hund),
      .tens  (an_tens),
      .ones  (an_ones)
   );

   assign mole_location = mole_q;
   assign level_mode    = level_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: instance A (3 rounds) checked every cycle against an event model,
// instance B (long game, short gap) drives score through BCD rollover and saturation.
module tb_mole_game_ctrl;

   localparam int          A_UP     = 8;
   localparam int          STEP     = 2;
   localparam int          MIN      = 4;
   localparam int          A_GAP    = 4;
   localparam int          A_ROUNDS = 3;
   localparam int          B_GAP    = 2;
   localparam int          B_ROUNDS = 10001;
   localparam logic [15:0] SEED     = 16'hACE1;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, start_a, level_a;
   logic [3:0] btn_a, mole_a, thou_a, hund_a, tens_a, ones_a;
   logic       reset_b, start_b, level_b;
   logic [3:0] btn_b, mole_b, thou_b, hund_b, tens_b, ones_b;

   mole_game_ctrl #(
      .UP_CYCLES(A_UP), .UP_STEP(STEP), .UP_MIN(MIN), .GAP_CYCLES(A_GAP),
      .ROUNDS(A_ROUNDS), .LFSR_SEED(SEED)
   ) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .btn(btn_a),
      .mole_location(mole_a), .level_mode(level_a),
      .an_thou(thou_a), .an_hund(hund_a), .an_tens(tens_a), .an_ones(ones_a)
   );

   mole_game_ctrl #(
      .UP_CYCLES(A_UP), .UP_STEP(STEP), .UP_MIN(MIN), .GAP_CYCLES(B_GAP),
      .ROUNDS(B_ROUNDS), .LFSR_SEED(SEED)
   ) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .btn(btn_b),
      .mole_location(mole_b), .level_mode(level_b),
      .an_thou(thou_b), .an_hund(hund_b), .an_tens(tens_b), .an_ones(ones_b)
   );

   int checks = 0;
   int passed = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [15:0] bcd16(input int n);
      return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
   endfunction

   // Shift right; when a 1 falls out, flip the bits for x^16, x^14, x^13 and x^11.
   function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
      logic [15:0] y;
      y = x >> 1;
      if (x[0]) y = y ^ (16'h8000 | 16'h2000 | 16'h1000 | 16'h0400);
      return y;
   endfunction

   // Event model of instance A: countdowns of visible and blank edges, score as an integer.
   logic [15:0] m_lfsr;
   int          m_score, m_window, m_left, m_blank, m_moles, m_mole;
   logic [1:0]  m_prev;
   bit          m_active, m_mode;

   task automatic end_mole();
      m_mole  = -1;
      m_moles = m_moles + 1;
      m_blank = A_GAP + 1;
   endtask

   always @(posedge clk) begin : model_a
      logic [15:0] cur;
      logic [1:0]  p;
      if (reset_a) begin
         m_lfsr = SEED; m_score = 0; m_window = A_UP; m_left = 0; m_blank = 0;
         m_moles = 0; m_mole = -1; m_prev = 2'd0; m_active = 1'b0; m_mode = 1'b1;
      end else begin
         cur    = m_lfsr;
         m_lfsr = lfsr_adv(m_lfsr);
         if (m_active) begin
            if (m_mole >= 0) begin
               p = m_mole[1:0];
               if (btn_a[p]) begin
                  m_score  = (m_score < 9999) ? m_score + 1 : 9999;
                  m_window = (m_window - STEP < MIN) ? MIN : m_window - STEP;
                  end_mole();
               end else if (btn_a != 4'b0000) begin
                  end_mole();
               end else begin
                  m_left = m_left - 1;
                  if (m_left == 0) end_mole();
               end
            end else begin
               m_blank = m_blank - 1;
               if (m_blank == 0) begin
                  if (m_moles == A_ROUNDS) begin
                     m_active = 1'b0;
                  end else begin
                     p = cur[1:0];
                     if (p == m_prev) p = p + 2'd1;
                     m_prev = p;
                     m_mole = int'(p);
                     m_left = m_window;
                     m_mode = 1'b0;
                  end
               end
            end
         end
         if (!m_active) begin
            m_mode = 1'b1;
            if (start_a) begin
               m_active = 1'b1; m_score = 0; m_moles = 0; m_window = A_UP; m_blank = 1;
            end
         end
      end
   end

   always @(negedge clk) begin : compare_a
      logic [3:0] em;
      if (cmp_en) begin
         em = (m_mole < 0) ? 4'hF : ~(4'b0001 << m_mole[1:0]);
         check("cycle_a", {mole_a, level_a, thou_a, hund_a, tens_a, ones_a},
               {em, m_mode, bcd16(m_score)});
      end
   end

   task automatic wait_vis_a(output int blanks);
      blanks = 0;
      while (mole_a == 4'hF && blanks < 100) begin @(negedge clk); blanks++; end
   endtask

   task automatic count_vis_a(output int vis);
      vis = 0;
      while (mole_a != 4'hF && vis < 100) begin @(negedge clk); vis++; end
   endtask

   task automatic wait_vis_b(output bit found);
      int k;
      k = 0;
      while (mole_b == 4'hF && k < 20) begin @(negedge clk); k++; end
      found = (mole_b != 4'hF);
   endtask

   task automatic count_vis_b(output int vis);
      vis = 0;
      while (mole_b != 4'hF && vis < 20) begin @(negedge clk); vis++; end
   endtask

   initial begin
      int         bl, vis, pos, k;
      logic [3:0] m2, m3;
      bit         found;

      reset_a = 1'b1; start_a = 1'b0; btn_a = 4'b0000;
      reset_b = 1'b1; start_b = 1'b0; btn_b = 4'b0000;
      repeat (3) @(negedge clk);

      check("rst_mole", mole_a, 4'hF);
      check("rst_level", level_a, 1'b1);
      check("rst_score", {thou_a, hund_a, tens_a, ones_a}, 16'h0000);
      cmp_en = 1'b1;

      // Game 1: start on the first edge out of reset; LFSR gives pos 0 == prev, so hole 1.
      reset_a = 1'b0; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      check("spawn_blank", mole_a, 4'hF);
      @(negedge clk);
      check("first_mole", mole_a, 4'b1101);
      check("first_level", level_a, 1'b0);
      @(negedge clk); btn_a = 4'b0010;
      @(negedge clk); btn_a = 4'b0000;
      check("hit_ones", ones_a, 4'd1);
      check("hit_clear", mole_a, 4'hF);

      // Blank span is the gap plus the spawn cycle; LFSR low bits 00 collide with hole 1? no: hole 0.
      wait_vis_a(bl);
      check("gap1_len", bl, A_GAP + 1);
      check("second_mole", mole_a, 4'b1110);
      m2 = mole_a;
      count_vis_a(vis);
      check("window_after_hit", vis, A_UP - STEP);
      check("timeout_score", ones_a, 4'd1);

      wait_vis_a(bl);
      check("gap2_len", bl, A_GAP + 1);
      m3 = mole_a;
      check("pos_changes", (m3 != m2), 1'b1);
      pos = m_mole;
      btn_a = 4'(1 << pos) | 4'(1 << ((pos + 1) % 4));
      @(negedge clk); btn_a = 4'b0000;
      check("combo_hit", ones_a, 4'd2);
      check("combo_clear", mole_a, 4'hF);

      k = 0;
      while (level_a == 1'b0 && k < 50) begin @(negedge clk); k++; end
      check("over_level", level_a, 1'b1);
      check("over_score", {thou_a, hund_a, tens_a, ones_a}, 16'h0002);
      repeat (3) @(negedge clk);
      check("over_held", {mole_a, thou_a, hund_a, tens_a, ones_a}, 20'hF0002);

      // Game 2: restart from OVER, then timeout, wrong button, reset mid-window.
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      check("restart_clr", {thou_a, hund_a, tens_a, ones_a}, 16'h0000);
      wait_vis_a(bl);
      count_vis_a(vis);
      check("window_full", vis, A_UP);
      check("timeout_no_score", ones_a, 4'd0);

      wait_vis_a(bl);
      pos = m_mole;
      btn_a = 4'(1 << ((pos + 2) % 4));
      @(negedge clk); btn_a = 4'b0000;
      check("wrong_clear", mole_a, 4'hF);
      check("wrong_score", ones_a, 4'd0);

      wait_vis_a(bl);
      repeat (2) @(negedge clk);
      check("still_up", (mole_a != 4'hF), 1'b1);
      reset_a = 1'b1;
      @(negedge clk);
      check("midrst", {mole_a, level_a, thou_a, hund_a, tens_a, ones_a}, {4'hF, 1'b1, 16'h0000});
      reset_a = 1'b0; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      @(negedge clk);
      check("reseeded_mole", mole_a, 4'b1101);

      // Instance B: hit every mole on its first visible cycle.
      reset_b = 1'b0; start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int h = 1; h <= 10000; h++) begin
         wait_vis_b(found);
         check("b_mole_up", found, 1'b1);
         if (!found) break;
         btn_b = ~mole_b;
         @(negedge clk); btn_b = 4'b0000;
         check("b_score", {thou_b, hund_b, tens_b, ones_b}, bcd16((h > 9999) ? 9999 : h));
         check("b_clear", mole_b, 4'hF);
         if (h == 10)    check("b_tens_roll", {tens_b, ones_b}, 8'h10);
         if (h == 9999)  check("b_at_max", {thou_b, hund_b, tens_b, ones_b}, 16'h9999);
         if (h == 10000) check("b_saturated", {thou_b, hund_b, tens_b, ones_b}, 16'h9999);
      end
      wait_vis_b(found);
      count_vis_b(vis);
      check("b_window_floor", vis, MIN);
      k = 0;
      while (level_b == 1'b0 && k < 20) begin @(negedge clk); k++; end
      check("b_over_level", level_b, 1'b1);
      check("b_over_score", {thou_b, hund_b, tens_b, ones_b}, 16'h9999);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
